board_move_ctrl: RTL and testbench
==================================

# board_move_ctrl

Parametrised N×N board move controller: accepts a (row, column) move over a valid/ready handshake, decodes it to a one-hot cell, checks range and occupancy, and commits it to the X or O board register for the player whose turn it is. It replaces the fixed 3×3 combinational row/column decoder in the game datapath. It feeds the board vectors to the win detector and display logic, and reports per-move accept/reject status to the player-input FSM.

## Interface
- N, 3, board dimension; legal range 2..15
- W, 2, coordinate width; must satisfy 2^W > N
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous new-game request
- halt  in  1  game-over flag from win detector; closes the board
- move_valid  in  1  move request
- move_ready  out  1  controller can accept a move
- move_row  in  W  row, 1-based (1..N legal)
- move_col  in  W  column, 1-based (1..N legal)
- rsp_valid  out  1  one-cycle result pulse
- rsp_ok  out  1  move committed (qualified by rsp_valid)
- rsp_err  out  2  00 none, 01 out of range, 10 occupied, 11 game closed
- cell_sel  out  N*N  one-hot of the decoded cell, valid with rsp_valid; zero if out of range
- x_board  out  N*N  X occupancy
- o_board  out  N*N  O occupancy
- turn  out  1  0 = X to move, 1 = O to move
- move_cnt  out  8  committed moves
- board_full  out  1  move_cnt == N*N

## Operation
- Cell index = (row−1)·N + (col−1). For N=3: (1,1)→bit 0, (1,3)→bit 2, (2,1)→bit 3, (3,3)→bit 8.
- Coordinate legal iff 1 ≤ value ≤ N. A value of 0 or greater than N is out of range.
- FSM states: IDLE, CHECK, RESP.
  - IDLE: move_ready=1. If move_valid, capture row and column, then go to CHECK.
  - CHECK: move_ready=0. Decode the captured coordinates and evaluate, then go to RESP. Error priority: game closed (halt=1 or board_full=1) > out of range > occupied (bit set in x_board|o_board).
  - RESP: rsp_valid=1 for one cycle, then go to IDLE.
- On commit (edge CHECK→RESP, ok):
  - set the cell bit in x_board if turn=0, else in o_board
  - toggle turn
  - increment move_cnt
- On reject: board, turn and move_cnt are unchanged. rsp_ok=0 and rsp_err carries the code.
- clear: highest priority, in any state.
  - Next state IDLE; boards, turn, move_cnt, rsp_* and cell_sel all zero.
  - An in-flight move is dropped with no rsp_valid.
  - A move_valid in the same cycle as clear is not captured.
- halt is sampled only in CHECK. A halt after commit does not undo the move.
- Captured coordinates are held internally. move_row and move_col may change after the handshake.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - state IDLE, move_ready=1
  - rsp_valid=0, rsp_ok=0, rsp_err=00
  - cell_sel=0, x_board=0, o_board=0
  - turn=0, move_cnt=0, board_full=0
- Reset mid-move aborts it with no response.
- Handshake at edge E0 (move_valid & move_ready). Board, turn, move_cnt and rsp_* update at E1; rsp_valid is high for the cycle after E1. move_ready returns high after E2.
- Throughput: one move per 3 cycles. Back-to-back move_valid is accepted at E0, E3, E6, …
- All outputs are registered except move_ready, which is decoded from state.
- board_full is registered and updates in the same cycle as move_cnt.

## Test plan
- Reset and basic commit, N=3. Reset, then move (1,1) → rsp_ok=1, x_board=9'h001, turn=1, move_cnt=1. Then move (3,3) → o_board=9'h100, turn=0.
- Occupied cell. Move (2,2) twice → second move gives rsp_ok=0, rsp_err=10, boards unchanged, turn unchanged.
- Out of range. Moves (0,1), (1,0) and (3,... with N=3, row 4 via W=3 build) → each gives rsp_err=01, cell_sel=0, move_cnt unchanged.
- Full board. Nine legal moves with no halt → board_full=1, x_board|o_board=9'h1FF. A tenth move gives rsp_err=11.
- Halt, clear and priority.
  - halt=1 with an occupied cell → rsp_err=11.
  - clear asserted in CHECK → no rsp_valid, all state zero, move_ready=1 next cycle.
  - rst_n dropped in RESP → outputs zero immediately.
- Parametrisation. N=4, W=3: move (4,4) → bit 15 set. Move (2,1) → bit 4. Move (5,1) → rsp_err=01. Sixteen moves → board_full=1.

Source files
------------

// File: rtl/board_move_ctrl_if.sv
// board_move_ctrl_if
//   Move request / response bundle between the player-input FSM (master)
//   and the board move controller (slave).
//   move_valid/move_ready/move_row/move_col : move request handshake
//   rsp_valid/rsp_ok/rsp_err/cell_sel       : one-cycle result of a move
interface board_move_ctrl_if #(
  parameter int N = 3,
  parameter int W = 2
);
  logic           move_valid;
  logic           move_ready;
  logic [W-1:0]   move_row;
  logic [W-1:0]   move_col;
  logic           rsp_valid;
  logic           rsp_ok;
  logic [1:0]     rsp_err;
  logic [N*N-1:0] cell_sel;

  modport master (
    output move_valid, move_row, move_col,
    input  move_ready, rsp_valid, rsp_ok, rsp_err, cell_sel
  );

  modport slave (
    input  move_valid, move_row, move_col,
    output move_ready, rsp_valid, rsp_ok, rsp_err, cell_sel
  );
endinterface

// File: rtl/board_move_ctrl.sv
// board_move_ctrl
//   N x N board move controller. Takes a 1-based (row, col) move over the
//   mv handshake, decodes it to a one-hot cell, checks game-closed / range /
//   occupancy and commits it to the X or O board for the side to move.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     clear       : synchronous new-game request, overrides everything
//     halt        : game-over flag, sampled only while checking a move
//     mv          : move request / response interface (slave side)
//     x_board     : X occupancy, bit (row-1)*N + (col-1)
//     o_board     : O occupancy
//     turn        : 0 = X to move, 1 = O to move
//     move_cnt    : committed moves
//     board_full  : move_cnt == N*N
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | ready for a move; captures row/col on move_valid
// CHECK  | decodes captured move, commits or rejects it
// RESP   | rsp_valid high for this cycle, then back to IDLE
module board_move_ctrl #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             halt,
  board_move_ctrl_if.slave mv,
  output logic [N*N-1:0]   x_board,
  output logic [N*N-1:0]   o_board,
  output logic             turn,
  output logic [7:0]       move_cnt,
  output logic             board_full
);

  localparam int               CELLS   = N * N;
  localparam logic [7:0]       N8      = 8'(N);
  localparam logic [7:0]       CELLS8  = 8'(CELLS);
  localparam logic [CELLS-1:0] ONE_HOT = {{(CELLS-1){1'b0}}, 1'b1};

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_RANGE  = 2'b01;
  localparam logic [1:0] ERR_OCC    = 2'b10;
  localparam logic [1:0] ERR_CLOSED = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]     row_q, row_d;
  logic [W-1:0]     col_q, col_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_ok_q, rsp_ok_d;
  logic [1:0]       rsp_err_q, rsp_err_d;
  logic [CELLS-1:0] cell_sel_q, cell_sel_d;
  logic [CELLS-1:0] x_q, x_d;
  logic [CELLS-1:0] o_q, o_d;
  logic             turn_q, turn_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             full_q, full_d;

  logic [7:0]       row_u, col_u, cell_idx;
  logic             range_ok, occupied, closed;
  logic [CELLS-1:0] cell_hot;
  logic [1:0]       err_code;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mv.move_valid) state_d = S_CHECK;
      S_CHECK: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear) state_d = S_IDLE;
  end

  // state-decoded output
  always_comb begin
    mv.move_ready = (state_q == S_IDLE);
  end

  // Move decode. Coordinates are widened to 8 bits so the index math is
  // the same for every legal N; an out-of-range index is masked by range_ok.
  always_comb begin
    row_u    = 8'(row_q);
    col_u    = 8'(col_q);
    range_ok = (row_u != 8'd0) && (row_u <= N8) &&
               (col_u != 8'd0) && (col_u <= N8);
    cell_idx = (row_u - 8'd1) * N8 + (col_u - 8'd1);
    cell_hot = range_ok ? (ONE_HOT << cell_idx) : '0;
    occupied = |(cell_hot & (x_q | o_q));
    closed   = halt | full_q;
    if (closed)         err_code = ERR_CLOSED;
    else if (!range_ok) err_code = ERR_RANGE;
    else if (occupied)  err_code = ERR_OCC;
    else                err_code = ERR_NONE;
  end

  // datapath next values
  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    rsp_valid_d = 1'b0;
    rsp_ok_d    = rsp_ok_q;
    rsp_err_d   = rsp_err_q;
    cell_sel_d  = cell_sel_q;
    x_d         = x_q;
    o_d         = o_q;
    turn_d      = turn_q;
    cnt_d       = cnt_q;

    if (clear) begin
      row_d      = '0;
      col_d      = '0;
      rsp_ok_d   = 1'b0;
      rsp_err_d  = ERR_NONE;
      cell_sel_d = '0;
      x_d        = '0;
      o_d        = '0;
      turn_d     = 1'b0;
      cnt_d      = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mv.move_valid) begin
            row_d = mv.move_row;
            col_d = mv.move_col;
          end
        end
        S_CHECK: begin
          rsp_valid_d = 1'b1;
          rsp_ok_d    = (err_code == ERR_NONE);
          rsp_err_d   = err_code;
          cell_sel_d  = cell_hot;
          if (err_code == ERR_NONE) begin
            if (turn_q) o_d = o_q | cell_hot;
            else        x_d = x_q | cell_hot;
            turn_d = ~turn_q;
            cnt_d  = cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end

    // registered alongside move_cnt so both change on the same edge
    full_d = (cnt_d == CELLS8);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= '0;
      col_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_ok_q    <= 1'b0;
      rsp_err_q   <= ERR_NONE;
      cell_sel_q  <= '0;
      x_q         <= '0;
      o_q         <= '0;
      turn_q      <= 1'b0;
      cnt_q       <= 8'd0;
      full_q      <= 1'b0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ok_q    <= rsp_ok_d;
      rsp_err_q   <= rsp_err_d;
      cell_sel_q  <= cell_sel_d;
      x_q         <= x_d;
      o_q         <= o_d;
      turn_q      <= turn_d;
      cnt_q       <= cnt_d;
      full_q      <= full_d;
    end
  end

  assign mv.rsp_valid = rsp_valid_q;
  assign mv.rsp_ok    = rsp_ok_q;
  assign mv.rsp_err   = rsp_err_q;
  assign mv.cell_sel  = cell_sel_q;
  assign x_board      = x_q;
  assign o_board      = o_q;
  assign turn         = turn_q;
  assign move_cnt     = cnt_q;
  assign board_full   = full_q;

endmodule

// File: tb/tb_board_move_ctrl.sv
// Directed bench for board_move_ctrl: a 3x3 instance (W=3 so row 4 can be
// presented) and a 4x4 instance share clk, rst_n, clear and halt.
module tb_board_move_ctrl;

  logic clk = 1'b0;
  logic rst_n, clear, halt;
  int   errors = 0;
  int   checks = 0;

  board_move_ctrl_if #(.N(3), .W(3)) if3 ();
  board_move_ctrl_if #(.N(4), .W(3)) if4 ();

  logic [8:0]  x3, o3;
  logic        turn3, full3;
  logic [7:0]  cnt3;
  logic [15:0] x4, o4;
  logic        turn4, full4;
  logic [7:0]  cnt4;

  board_move_ctrl #(.N(3), .W(3)) u3 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .halt(halt), .mv(if3),
    .x_board(x3), .o_board(o3), .turn(turn3), .move_cnt(cnt3), .board_full(full3)
  );

  board_move_ctrl #(.N(4), .W(3)) u4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .halt(halt), .mv(if4),
    .x_board(x4), .o_board(o4), .turn(turn4), .move_cnt(cnt4), .board_full(full4)
  );

  always #5 clk = ~clk;

  // last sampled outputs of the selected instance
  logic        s_vld, s_ok, s_trn, s_full, s_rdy;
  logic [1:0]  s_err;
  logic [15:0] s_cs, s_xb, s_ob;
  logic [7:0]  s_cnt;

  task automatic sample(input int sel);
    if (sel == 3) begin
      s_vld = if3.rsp_valid; s_ok = if3.rsp_ok; s_err = if3.rsp_err;
      s_cs = 16'(if3.cell_sel); s_xb = 16'(x3); s_ob = 16'(o3);
      s_trn = turn3; s_cnt = cnt3; s_full = full3; s_rdy = if3.move_ready;
    end else begin
      s_vld = if4.rsp_valid; s_ok = if4.rsp_ok; s_err = if4.rsp_err;
      s_cs = if4.cell_sel; s_xb = x4; s_ob = o4;
      s_trn = turn4; s_cnt = cnt4; s_full = full4; s_rdy = if4.move_ready;
    end
  endtask

  // Starts and ends on a falling edge; samples at the falling edge after E1.
  task automatic do_move(input int sel, input logic [2:0] r, input logic [2:0] c);
    int waits;
    waits = 0;
    sample(sel);
    while (!s_rdy && waits < 10) begin
      @(negedge clk);
      sample(sel);
      waits++;
    end
    checks++;
    if (s_rdy !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: move_ready=%b after %0d cycles, required 1", s_rdy, waits);
    end
    if (sel == 3) begin
      if3.move_valid = 1'b1; if3.move_row = r; if3.move_col = c;
    end else begin
      if4.move_valid = 1'b1; if4.move_row = r; if4.move_col = c;
    end
    @(negedge clk);
    // scramble coordinates after the handshake; the captured copy must be used
    if (sel == 3) begin
      if3.move_valid = 1'b0; if3.move_row = ~r; if3.move_col = ~c;
    end else begin
      if4.move_valid = 1'b0; if4.move_row = ~r; if4.move_col = ~c;
    end
    @(negedge clk);
    sample(sel);
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    sample(3);
    checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", s_rdy); end
    checks++; if ({s_vld, s_ok, s_err} !== 4'b0) begin errors++; $display("FAIL reset_rsp: got %b want 0000", {s_vld, s_ok, s_err}); end
    checks++; if ({s_cs, s_xb, s_ob} !== 48'h0) begin errors++; $display("FAIL reset_boards: got %h want 0", {s_cs, s_xb, s_ob}); end
    checks++; if ({s_trn, s_full, s_cnt} !== 10'h0) begin errors++; $display("FAIL reset_turn_cnt: got %h want 0", {s_trn, s_full, s_cnt}); end
    sample(4);
    checks++; if ({s_rdy, s_xb, s_cnt} !== {1'b1, 16'h0, 8'h0}) begin errors++; $display("FAIL reset_n4: got %h want 10000000", {s_rdy, s_xb, s_cnt}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_commit();
    do_move(3, 3'd1, 3'd1);
    checks++; if ({s_vld, s_ok, s_err} !== 4'b1100) begin errors++; $display("FAIL basic11_rsp: got %b want 1100", {s_vld, s_ok, s_err}); end
    checks++; if (s_xb !== 16'h001) begin errors++; $display("FAIL basic11_x: got %h want 001", s_xb); end
    checks++; if (s_cs !== 16'h001) begin errors++; $display("FAIL basic11_cell: got %h want 001", s_cs); end
    checks++; if ({s_trn, s_cnt} !== {1'b1, 8'd1}) begin errors++; $display("FAIL basic11_turn_cnt: got %h want 101", {s_trn, s_cnt}); end
    do_move(3, 3'd3, 3'd3);
    checks++; if (s_ob !== 16'h100) begin errors++; $display("FAIL basic33_o: got %h want 100", s_ob); end
    checks++; if ({s_trn, s_cnt} !== {1'b0, 8'd2}) begin errors++; $display("FAIL basic33_turn_cnt: got %h want 002", {s_trn, s_cnt}); end
    sample(3);
    checks++; if ({s_vld, s_rdy} !== 2'b01) begin errors++; $display("FAIL basic_after_resp: got vld,rdy=%b want 01", {s_vld, s_rdy}); end
  endtask

  task automatic test_occupied();
    do_move(3, 3'd2, 3'd2);
    checks++; if ({s_ok, s_xb} !== {1'b1, 16'h011}) begin errors++; $display("FAIL occ_first: got %h want 1_0011", {s_ok, s_xb}); end
    do_move(3, 3'd2, 3'd2);
    checks++; if ({s_vld, s_ok, s_err} !== 4'b1010) begin errors++; $display("FAIL occ_rsp: got %b want 1010", {s_vld, s_ok, s_err}); end
    checks++; if ({s_xb, s_ob} !== {16'h011, 16'h100}) begin errors++; $display("FAIL occ_boards: got %h want 00110100", {s_xb, s_ob}); end
    checks++; if ({s_trn, s_cnt} !== {1'b1, 8'd3}) begin errors++; $display("FAIL occ_turn_cnt: got %h want 103", {s_trn, s_cnt}); end
    checks++; if (s_cs !== 16'h010) begin errors++; $display("FAIL occ_cell: got %h want 010", s_cs); end
  endtask

  task automatic test_out_of_range();
    logic [2:0] rr [3];
    logic [2:0] cc [3];
    rr = '{3'd0, 3'd1, 3'd4};
    cc = '{3'd1, 3'd0, 3'd1};
    for (int i = 0; i < 3; i++) begin
      do_move(3, rr[i], cc[i]);
      checks++; if ({s_vld, s_ok, s_err} !== 4'b1001) begin errors++; $display("FAIL oor_rsp%0d: got %b want 1001", i, {s_vld, s_ok, s_err}); end
      checks++; if (s_cs !== 16'h0) begin errors++; $display("FAIL oor_cell%0d: got %h want 0", i, s_cs); end
      checks++; if ({s_trn, s_cnt} !== {1'b1, 8'd3}) begin errors++; $display("FAIL oor_turn_cnt%0d: got %h want 103", i, {s_trn, s_cnt}); end
    end
  endtask

  task automatic test_full_board();
    do_clear();
    sample(3);
    checks++; if ({s_xb, s_ob, s_cnt, s_trn} !== 41'h0) begin errors++; $display("FAIL full_clear: got %h want 0", {s_xb, s_ob, s_cnt, s_trn}); end
    for (int r = 1; r <= 3; r++) begin
      for (int c = 1; c <= 3; c++) begin
        do_move(3, 3'(r), 3'(c));
        checks++; if (s_ok !== 1'b1) begin errors++; $display("FAIL full_move_%0d%0d: ok=%b err=%b want ok=1", r, c, s_ok, s_err); end
        checks++; if (s_full !== (r == 3 && c == 3)) begin errors++; $display("FAIL full_flag_%0d%0d: got %b", r, c, s_full); end
      end
    end
    checks++; if ((s_xb | s_ob) !== 16'h1FF) begin errors++; $display("FAIL full_union: got %h want 1ff", s_xb | s_ob); end
    checks++; if ({s_xb, s_ob} !== {16'h155, 16'h0AA}) begin errors++; $display("FAIL full_split: got %h want 015500aa", {s_xb, s_ob}); end
    checks++; if (s_cnt !== 8'd9) begin errors++; $display("FAIL full_cnt: got %0d want 9", s_cnt); end
    do_move(3, 3'd1, 3'd1);
    checks++; if ({s_vld, s_ok, s_err} !== 4'b1011) begin errors++; $display("FAIL full_tenth: got %b want 1011", {s_vld, s_ok, s_err}); end
    checks++; if (s_cnt !== 8'd9) begin errors++; $display("FAIL full_tenth_cnt: got %0d want 9", s_cnt); end
  endtask

  task automatic test_halt();
    do_clear();
    do_move(3, 3'd1, 3'd1);
    checks++; if ({s_ok, s_full} !== 2'b10) begin errors++; $display("FAIL halt_pre: got ok,full=%b want 10", {s_ok, s_full}); end
    halt = 1'b1;
    do_move(3, 3'd1, 3'd1);
    checks++; if ({s_ok, s_err} !== 3'b011) begin errors++; $display("FAIL halt_occupied: got %b want 011", {s_ok, s_err}); end
    do_move(3, 3'd2, 3'd2);
    checks++; if ({s_ok, s_err} !== 3'b011) begin errors++; $display("FAIL halt_free: got %b want 011", {s_ok, s_err}); end
    checks++; if ({s_xb, s_ob, s_trn, s_cnt} !== {16'h001, 16'h0, 1'b1, 8'd1}) begin errors++; $display("FAIL halt_state: got %h", {s_xb, s_ob, s_trn, s_cnt}); end
    halt = 1'b0;
    do_move(3, 3'd2, 3'd2);
    checks++; if ({s_ok, s_ob, s_cnt} !== {1'b1, 16'h010, 8'd2}) begin errors++; $display("FAIL halt_release: got %h want 1_0010_02", {s_ok, s_ob, s_cnt}); end
  endtask

  task automatic test_clear();
    // clear while the move sits in CHECK
    if3.move_valid = 1'b1; if3.move_row = 3'd3; if3.move_col = 3'd1;
    @(negedge clk);
    if3.move_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    sample(3);
    checks++; if ({s_vld, s_ok, s_err, s_cs} !== 20'h0) begin errors++; $display("FAIL clr_check_rsp: got %h want 0", {s_vld, s_ok, s_err, s_cs}); end
    checks++; if ({s_xb, s_ob, s_trn, s_cnt, s_full} !== 42'h0) begin errors++; $display("FAIL clr_check_state: got %h want 0", {s_xb, s_ob, s_trn, s_cnt}); end
    checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL clr_check_ready: got %b want 1", s_rdy); end
    @(negedge clk);
    sample(3);
    checks++; if ({s_vld, s_xb} !== 17'h0) begin errors++; $display("FAIL clr_check_late: got %h want 0", {s_vld, s_xb}); end
    // move_valid coincident with clear is not captured
    if3.move_valid = 1'b1; if3.move_row = 3'd1; if3.move_col = 3'd1;
    clear = 1'b1;
    @(negedge clk);
    if3.move_valid = 1'b0;
    clear = 1'b0;
    sample(3);
    checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL clr_same_ready: got %b want 1", s_rdy); end
    @(negedge clk);
    @(negedge clk);
    sample(3);
    checks++; if ({s_vld, s_xb, s_cnt} !== 25'h0) begin errors++; $display("FAIL clr_same_state: got %h want 0", {s_vld, s_xb, s_cnt}); end
  endtask

  task automatic test_reset_in_resp();
    if3.move_valid = 1'b1; if3.move_row = 3'd2; if3.move_col = 3'd3;
    @(negedge clk);
    if3.move_valid = 1'b0;
    @(negedge clk);
    sample(3);
    checks++; if ({s_vld, s_xb} !== {1'b1, 16'h020}) begin errors++; $display("FAIL rst_resp_pre: got %h want 1_0020", {s_vld, s_xb}); end
    #1 rst_n = 1'b0;
    #1;
    sample(3);
    checks++; if ({s_vld, s_ok, s_cs, s_xb, s_cnt, s_trn} !== 43'h0) begin errors++; $display("FAIL rst_resp_zero: got %h want 0", {s_vld, s_ok, s_cs, s_xb, s_cnt, s_trn}); end
    checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL rst_resp_ready: got %b want 1", s_rdy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_clear();
    if3.move_valid = 1'b1; if3.move_row = 3'd1; if3.move_col = 3'd1;
    for (int p = 0; p < 9; p++) begin
      @(negedge clk);
      sample(3);
      checks++; if (s_vld !== (p % 3 == 1)) begin errors++; $display("FAIL b2b_vld_p%0d: got %b", p, s_vld); end
      checks++; if (s_rdy !== (p % 3 == 2)) begin errors++; $display("FAIL b2b_rdy_p%0d: got %b", p, s_rdy); end
      if (p % 3 == 0) if3.move_col = 3'(p / 3 + 2);
      if (p == 8) if3.move_valid = 1'b0;
    end
    sample(3);
    checks++; if ({s_xb, s_ob, s_cnt} !== {16'h005, 16'h002, 8'd3}) begin errors++; $display("FAIL b2b_final: got %h want 0005000203", {s_xb, s_ob, s_cnt}); end
  endtask

  task automatic test_param_n4();
    do_clear();
    do_move(4, 3'd4, 3'd4);
    checks++; if ({s_ok, s_cs, s_xb} !== {1'b1, 16'h8000, 16'h8000}) begin errors++; $display("FAIL n4_44: got %h", {s_ok, s_cs, s_xb}); end
    do_move(4, 3'd2, 3'd1);
    checks++; if ({s_ok, s_cs, s_ob} !== {1'b1, 16'h0010, 16'h0010}) begin errors++; $display("FAIL n4_21: got %h", {s_ok, s_cs, s_ob}); end
    do_move(4, 3'd5, 3'd1);
    checks++; if ({s_err, s_cs, s_cnt} !== {2'b01, 16'h0, 8'd2}) begin errors++; $display("FAIL n4_51: got %h want 1_0000_02", {s_err, s_cs, s_cnt}); end
    do_clear();
    for (int r = 1; r <= 4; r++) begin
      for (int c = 1; c <= 4; c++) begin
        do_move(4, 3'(r), 3'(c));
      end
    end
    checks++; if ({s_full, s_cnt} !== {1'b1, 8'd16}) begin errors++; $display("FAIL n4_full: got %h want 110", {s_full, s_cnt}); end
    checks++; if ({s_xb, s_ob} !== {16'h5555, 16'hAAAA}) begin errors++; $display("FAIL n4_boards: got %h want 5555aaaa", {s_xb, s_ob}); end
    do_move(4, 3'd1, 3'd1);
    checks++; if ({s_ok, s_err} !== 3'b011) begin errors++; $display("FAIL n4_extra: got %b want 011", {s_ok, s_err}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    clear = 1'b0;
    halt  = 1'b0;
    if3.move_valid = 1'b0; if3.move_row = '0; if3.move_col = '0;
    if4.move_valid = 1'b0; if4.move_row = '0; if4.move_col = '0;
    #2;
    test_reset();
    test_basic_commit();
    test_occupied();
    test_out_of_range();
    test_full_board();
    test_halt();
    test_clear();
    test_reset_in_resp();
    test_back_to_back();
    test_param_n4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
